pcm_output_stage: RTL and testbench
===================================

PCM_OUTPUT_STAGE -- requirements
Module: pcm_output_stage

Interface
REQ-001 Parameter FRAC_BITS, default 27: fraction bits of the input sample; full scale ±1.0 = ±2^27.
REQ-002 Parameter FIFO_DEPTH, default 1024: PCM FIFO depth in 16-bit words (power of two).
REQ-003 Parameter START_LEVEL, default 576: FIFO fill (one granule) that starts playback.
REQ-004 Parameter BCLK_DIV, default 16: clk cycles per i2s_bclk half-period.
REQ-005 clk  in  1  system clock; all logic on rising edge; one clock domain.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 sample_in  in  32  signed two's-complement synthesized PCM sample from subband_synthesis.
REQ-008 sample_valid_in  in  1  sample_in is valid this cycle.
REQ-009 sample_ready_out  out  1  high when the FIFO is not full.
REQ-010 i2s_bclk  out  1  I2S bit clock.
REQ-011 i2s_lrclk  out  1  I2S word select: 0 = left, 1 = right.
REQ-012 i2s_sdata  out  1  I2S serial data, MSB first.
REQ-013 fifo_count  out  $clog2(FIFO_DEPTH)+1  number of words in the FIFO.
REQ-014 underrun  out  1  sticky: a frame started while the FIFO was empty.
REQ-015 overflow  out  1  sticky: a sample was dropped because the FIFO was full.

Function
REQ-016 Conversion SHALL be one registered stage: pcm = sat16((sample_in + 2^(FRAC_BITS-16)) >>> (FRAC_BITS-15)); the add is 33-bit, so it cannot wrap.
REQ-017 sat16 SHALL clamp the result to [-32768, 32767].
REQ-018 A converted word SHALL be written to the FIFO on the cycle after sample_valid_in is high; write latency is 2 cycles from input to fifo_count increment.
REQ-019 If the FIFO is full when a write is due, the word SHALL be dropped, the FIFO left unchanged, and overflow set.
REQ-020 fifo_count SHALL update the same cycle as a push or pop; a simultaneous push and pop SHALL leave it unchanged.
REQ-021 The FIFO SHALL use wrap-around read and write pointers with an extra MSB for the full/empty distinction.
REQ-022 The controller SHALL have three states, IDLE -> PRIME -> RUN.
REQ-023 IDLE (after reset): i2s_bclk=0, i2s_lrclk=1, i2s_sdata=0, no pops; go to PRIME on the first cycle sample_valid_in is high.
REQ-024 PRIME: hold the IDLE outputs; go to RUN when fifo_count >= START_LEVEL.
REQ-025 RUN SHALL run continuously until reset, even on underrun.
REQ-026 Divider: a counter 0..BCLK_DIV-1 toggles i2s_bclk on wrap.
REQ-027 i2s_lrclk and i2s_sdata SHALL change only on the clk cycle where i2s_bclk falls.
REQ-028 A 5-bit slot counter 0..31 SHALL advance on each bclk falling edge.
REQ-029 i2s_lrclk SHALL be 0 for slots 0-15 and 1 for slots 16-31.
REQ-030 At slot 0 the FIFO head SHALL be popped into the left and right shift registers (mono, duplicated); if the FIFO is empty, 0x0000 is loaded and underrun is set.
REQ-031 Philips framing: slots 1-16 carry left bits 15..0.
REQ-032 Slots 17-31 carry right bits 15..1, and slot 0 of the next frame carries right bit 0.
REQ-033 The first RUN frame SHALL start at slot 0 with sdata=0.
REQ-034 One stereo frame SHALL be 64*BCLK_DIV clk cycles (1024 at default; 48.83 kHz at 50 MHz).

Reset
REQ-035 rst SHALL apply at any time, including mid-frame: next cycle FIFO empty, fifo_count=0, underrun=0, overflow=0, sample_ready_out=1, state IDLE.
REQ-036 rst SHALL also force i2s_bclk=0, i2s_lrclk=1, i2s_sdata=0, divider and slot counters to 0, and discard the pipeline stage.

Verification
REQ-037 Conversion: sample_in 0x08000000 -> 0x7FFF; 0x00001800 -> 0x0002; 0xFFFFF800 -> 0x0000; 0xF0000000 -> 0x8000 (read from FIFO/I2S).
REQ-038 Start: 576 consecutive valid samples at 1 per clk -> fifo_count=576 two cycles after the last; RUN entered; first lrclk fall within BCLK_DIV*2 cycles; fifo_count drops by 1 per 1024 clks.
REQ-039 I2S framing: single word 0x8001 -> sdata slots 1-16 = 1,0x14,1 and slots 17-31 plus next slot 0 identical; lrclk period 1024 clks.
REQ-040 Underrun: START_LEVEL samples, then no input -> after 576 frames the next slot 0 loads zero, underrun=1, sdata stays 0, bclk keeps running.
REQ-041 Overflow: 1100 back-to-back samples in PRIME with START_LEVEL forced above 1024 -> fifo_count=1024, sample_ready_out=0, overflow=1.
REQ-042 Reset mid-frame: rst pulse at slot 20 of RUN -> next cycle all outputs at reset values; 576 new samples restart playback cleanly.

Source files
------------

// File: rtl/pcm_output_stage.sv
// PCM output stage: rounds/saturates synthesized samples to 16 bits,
// buffers them in a FIFO and streams mono-duplicated Philips I2S.
module pcm_output_stage #(
    parameter int FRAC_BITS   = 27,
    parameter int FIFO_DEPTH  = 1024,
    parameter int START_LEVEL = 576,
    parameter int BCLK_DIV    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   sample_in,
    input  logic                          sample_valid_in,
    output logic                          sample_ready_out,
    output logic                          i2s_bclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          underrun,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int SH = FRAC_BITS - 15;
    localparam logic signed [32:0] RND = 33'sd1 <<< (FRAC_BITS - 16);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t state, state_nx;

    logic signed [32:0] sum_w;
    logic signed [32:0] shf_w;
    logic [15:0]        sat_w;
    logic               conv_valid;
    logic [15:0]        conv_word;

    logic [AW:0]        wr_ptr, rd_ptr;
    logic [15:0]        mem [FIFO_DEPTH];
    logic [15:0]        head;
    logic               full, empty, push, pop;

    logic [DW-1:0]      div_cnt;
    logic               div_wrap, fall, run;
    logic [4:0]         slot;
    logic [3:0]         bit_idx;
    logic [15:0]        pcm_word;

    // 33-bit add keeps the rounding offset from wrapping at +full scale
    assign sum_w = $signed({sample_in[31], sample_in}) + RND;
    assign shf_w = sum_w >>> SH;

    always_comb begin
        if (shf_w > 33'sd32767)
            sat_w = 16'h7fff;
        else if (shf_w < -33'sd32768)
            sat_w = 16'h8000;
        else
            sat_w = shf_w[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conv_valid <= 1'b0;
            conv_word  <= 16'h0000;
        end else begin
            conv_valid <= sample_valid_in;
            conv_word  <= sat_w;
        end
    end

    assign fifo_count       = wr_ptr - rd_ptr;
    assign empty            = (wr_ptr == rd_ptr);
    assign full             = (wr_ptr[AW] != rd_ptr[AW]) &&
                              (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign sample_ready_out = !full;
    assign head             = mem[rd_ptr[AW-1:0]];

    assign run      = (state == RUN);
    assign div_wrap = (div_cnt == DW'(BCLK_DIV - 1));
    assign fall     = run && div_wrap && i2s_bclk;
    assign push     = conv_valid && !full;
    assign pop      = fall && (slot == 5'd0) && !empty;

    // Left slots 1..16 and right slots 17..31,0 both map to bit (-slot) mod 16
    assign bit_idx = 4'd0 - slot[3:0];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= conv_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (sample_valid_in) state_nx = PRIME;
            PRIME:   if (int'(fifo_count) >= START_LEVEL) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b1;
            i2s_sdata <= 1'b0;
            slot      <= 5'd0;
            pcm_word  <= 16'h0000;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (conv_valid && full)
                overflow <= 1'b1;
            if (run) begin
                div_cnt <= div_wrap ? '0 : div_cnt + DW'(1);
                if (div_wrap)
                    i2s_bclk <= ~i2s_bclk;
            end
            if (fall) begin
                slot      <= slot + 5'd1;
                i2s_lrclk <= slot[4];
                i2s_sdata <= pcm_word[bit_idx];
                if (slot == 5'd0) begin
                    pcm_word <= empty ? 16'h0000 : head;
                    if (empty)
                        underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcm_output_stage.sv
// Scoreboard bench for pcm_output_stage: expected PCM words are queued at
// stimulus time and compared against words deserialized from the I2S pins.
module tb_pcm_output_stage;

    localparam int FD    = 16;
    localparam int SL    = 8;
    localparam int BD    = 2;
    localparam int FRAME = 64 * BD;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sample_in;
    logic        sample_valid_in;
    logic        sample_ready_out;
    logic        i2s_bclk, i2s_lrclk, i2s_sdata;
    logic [$clog2(FD):0] fifo_count;
    logic        underrun, overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    pcm_output_stage #(
        .FRAC_BITS(27), .FIFO_DEPTH(FD), .START_LEVEL(SL), .BCLK_DIV(BD)
    ) dut (
        .clk(clk), .rst(rst),
        .sample_in(sample_in), .sample_valid_in(sample_valid_in),
        .sample_ready_out(sample_ready_out),
        .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
        .fifo_count(fifo_count), .underrun(underrun), .overflow(overflow)
    );

    logic [31:0] a_in  [8] = '{32'h08000000, 32'h00001800, 32'hFFFFF800,
                              32'hF0000000, 32'hF8001000, 32'h7FFFFFFF,
                              32'h80000000, 32'h00000800};
    logic [15:0] a_exp [8] = '{16'h7FFF, 16'h0002, 16'h0000, 16'h8000,
                              16'h8001, 16'h7FFF, 16'h8000, 16'h0001};
    logic [31:0] b_in  [8] = '{32'hFFFFF7FF, 32'h00003000, 32'h07FFF000,
                              32'h00000800, 32'h01234000, 32'hFEDCB000,
                              32'h000007FF, 32'hFFFFF000};
    logic [15:0] b_exp [8] = '{16'hFFFF, 16'h0003, 16'h7FFF, 16'h0001,
                              16'h1234, 16'hEDCB, 16'h0000, 16'hFFFF};

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] s);
        sample_in       = s;
        sample_valid_in = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_lr_fall(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!i2s_lrclk) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // I2S receiver: sample sdata on bclk rise, frame on lrclk fall
    int          slot;
    bit          synced, have_word, prev_lr, prev_bclk;
    logic [15:0] mon_l, mon_r, want;

    always @(negedge clk) begin
        if (rst) begin
            synced    = 1'b0;
            have_word = 1'b0;
            prev_lr   = 1'b1;
            prev_bclk = 1'b0;
        end else begin
            if (i2s_bclk && !prev_bclk) begin
                if (prev_lr && !i2s_lrclk) begin
                    slot   = 0;
                    synced = 1'b1;
                end else if (synced) begin
                    slot++;
                end
                if (synced) begin
                    if (slot == 0) begin
                        if (have_word) begin
                            mon_r[0] = i2s_sdata;
                            want = (exp_q.size() != 0) ? exp_q.pop_front()
                                                       : 16'h0000;
                            check("frame_left", mon_l, want);
                            check("frame_right", mon_r, want);
                        end else begin
                            check("first_slot0_sdata", i2s_sdata, 0);
                        end
                        have_word = 1'b1;
                    end else if (slot <= 16) begin
                        mon_l[16-slot] = i2s_sdata;
                    end else if (slot <= 31) begin
                        mon_r[32-slot] = i2s_sdata;
                    end
                end
                prev_lr = i2s_lrclk;
            end
            prev_bclk = i2s_bclk;
        end
    end

    initial begin
        bit ok;
        int ones, toggles, falls;
        logic pb;
        rst = 1'b1;
        sample_in = '0;
        sample_valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_bclk", i2s_bclk, 0);
        check("rst_lrclk", i2s_lrclk, 1);
        check("rst_sdata", i2s_sdata, 0);
        check("rst_count", fifo_count, 0);
        check("rst_underrun", underrun, 0);
        check("rst_overflow", overflow, 0);
        check("rst_ready", sample_ready_out, 1);

        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(a_exp[i]);
            drive(a_in[i]);
        end
        sample_valid_in = 1'b0;
        @(posedge clk);
        #1 check("count_after_fill", fifo_count, SL);
        check("bclk_idle_in_prime", i2s_bclk, 0);
        wait_lr_fall(2 * BD + 2, ok);
        check("first_lrclk_fall", ok, 1);
        check("count_first_pop", fifo_count, SL - 1);
        repeat (FRAME) @(negedge clk);
        check("count_second_pop", fifo_count, SL - 2);

        for (int i = 0; i < 10 * FRAME && !underrun; i++) @(negedge clk);
        check("underrun_set", underrun, 1);
        check("count_empty", fifo_count, 0);
        check("no_overflow", overflow, 0);
        repeat (4) @(negedge clk);
        pb = i2s_bclk;
        ones = 0;
        toggles = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i2s_bclk != pb) toggles++;
            pb = i2s_bclk;
            if (i < FRAME - 8 && i2s_sdata) ones++;
        end
        check("underrun_sdata_zero", ones, 0);
        check("underrun_bclk_runs", toggles, FRAME / 2);

        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (i2s_lrclk) begin
                ok = 1'b1;
                break;
            end
        end
        check("lrclk_rise", ok, 1);
        pb = i2s_bclk;
        falls = 0;
        for (int i = 0; i < 8 * BD + 8 && falls < 4; i++) begin
            @(negedge clk);
            if (pb && !i2s_bclk) falls++;
            pb = i2s_bclk;
        end
        check("reach_slot20", falls, 4);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        check("mid_rst_bclk", i2s_bclk, 0);
        check("mid_rst_lrclk", i2s_lrclk, 1);
        check("mid_rst_sdata", i2s_sdata, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_underrun", underrun, 0);
        check("mid_rst_ready", sample_ready_out, 1);

        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(b_exp[i]);
            drive(b_in[i]);
        end
        sample_valid_in = 1'b0;
        @(posedge clk);
        #1 check("restart_count", fifo_count, SL);
        wait_lr_fall(2 * BD + 2, ok);
        check("restart_lrclk_fall", ok, 1);
        check("restart_count_pop", fifo_count, SL - 1);

        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            if (i < FD - (SL - 1))
                exp_q.push_back(16'(16'h0100 + i));
            drive(32'(32'h100 + i) << 12);
        end
        sample_valid_in = 1'b0;
        @(posedge clk);
        #1 check("ovf_count", fifo_count, FD);
        check("ovf_ready", sample_ready_out, 0);
        check("ovf_flag", overflow, 1);

        for (int i = 0; i < 20 * FRAME && exp_q.size() != 0; i++)
            @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        repeat (2 * FRAME) @(negedge clk);
        check("final_underrun", underrun, 1);
        check("final_ready", sample_ready_out, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
